// File: rtl/run_controller.sv
// Host-side start/halt sequencer: launches a core run, counts RUN cycles, then reads back
// RESULT_WORDS result bytes with a running checksum. Optional timeout: RUN_CTRL_CYCLE_LIMIT_EN.
module run_controller #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 8,
  parameter int CNT_W        = 16,
  parameter int START_CYCLES = 2,
  parameter int MAX_CYCLES   = 1000,
  parameter int RESULT_BASE  = 0,
  parameter int RESULT_WORDS = 4
) (
  input  logic                            clk,
  input  logic                            start,
  input  logic                            go,
  output logic                            cpu_start,
  input  logic                            cpu_halt,
  output logic                            mem_rd_en,
  output logic [ADDR_W-1:0]               mem_addr,
  input  logic [DATA_W-1:0]               mem_rd_data,
  output logic                            result_valid,
  output logic [DATA_W-1:0]               result_data,
  output logic [$clog2(RESULT_WORDS):0]   result_idx,
  output logic                            busy,
  output logic                            done,
  output logic                            timeout,
  output logic [CNT_W-1:0]                cycle_count,
  output logic [DATA_W-1:0]               checksum
);

  localparam int IDX_W = $clog2(RESULT_WORDS) + 1;
  localparam int SC_W  = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam logic [SC_W-1:0]   START_LAST = SC_W'(START_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(RESULT_WORDS - 1);
  localparam logic [ADDR_W-1:0] ADDR_FIRST = ADDR_W'(RESULT_BASE);
`ifdef RUN_CTRL_CYCLE_LIMIT_EN
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_LIMIT  = CNT_W'(MAX_CYCLES);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state;
  logic [SC_W-1:0]   start_cnt;
  logic [IDX_W-1:0]  rd_idx;
  logic              data_ph;
  logic [IDX_W-1:0]  data_idx;

`ifdef RUN_CTRL_CYCLE_LIMIT_EN
  logic timeout_q;
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  // data_ph marks the cycle in which mem_rd_data answers the previous cycle's request
  always_ff @(posedge clk) begin
    if (start) begin
      state        <= S_IDLE;
      cpu_start    <= 1'b0;
      mem_rd_en    <= 1'b0;
      mem_addr     <= '0;
      result_valid <= 1'b0;
      result_data  <= '0;
      result_idx   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      cycle_count  <= '0;
      checksum     <= '0;
      start_cnt    <= '0;
      rd_idx       <= '0;
      data_ph      <= 1'b0;
      data_idx     <= '0;
`ifdef RUN_CTRL_CYCLE_LIMIT_EN
      timeout_q    <= 1'b0;
`endif
    end else begin
      data_ph      <= mem_rd_en;
      data_idx     <= rd_idx;
      result_valid <= data_ph;
      if (data_ph) begin
        result_data <= mem_rd_data;
        result_idx  <= data_idx;
        checksum    <= checksum + mem_rd_data;
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (go) begin
            state       <= S_START;
            cpu_start   <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
            cycle_count <= '0;
            checksum    <= '0;
            rd_idx      <= '0;
            start_cnt   <= '0;
`ifdef RUN_CTRL_CYCLE_LIMIT_EN
            timeout_q   <= 1'b0;
`endif
          end
        end

        S_START: begin
          if (start_cnt == START_LAST) begin
            cpu_start <= 1'b0;
            state     <= S_RUN;
          end else begin
            start_cnt <= start_cnt + 1'b1;
          end
        end

        S_RUN: begin
          if (cpu_halt) begin
            state     <= S_READ;
            mem_rd_en <= 1'b1;
            mem_addr  <= ADDR_FIRST;
            rd_idx    <= '0;
          end
`ifdef RUN_CTRL_CYCLE_LIMIT_EN
          else if (cycle_count == CNT_LAST) begin
            cycle_count <= CNT_LIMIT;
            timeout_q   <= 1'b1;
            state       <= S_DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
          end else begin
            cycle_count <= cycle_count + 1'b1;
          end
`else
          else if (cycle_count != '1) begin
            cycle_count <= cycle_count + 1'b1;
          end
`endif
        end

        S_READ: begin
          if (rd_idx == IDX_LAST) begin
            mem_rd_en <= 1'b0;
            state     <= S_DRAIN;
          end else begin
            rd_idx   <= rd_idx + 1'b1;
            mem_addr <= mem_addr + 1'b1;
          end
        end

        S_DRAIN: begin
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_run_controller.sv
// Self-checking bench for run_controller; the timeout scenario runs when
// RUN_CTRL_CYCLE_LIMIT_EN is defined, otherwise the unlimited-run behaviour is checked.
module tb_run_controller;

  localparam int W    = 4;
  localparam int S    = 2;
  localparam int M    = 20;
  localparam int BASE = 0;

  logic        clk = 1'b0;
  logic        start, go, cpu_start, cpu_halt, mem_rd_en;
  logic        result_valid, busy, done, timeout;
  logic [7:0]  mem_addr, result_data, checksum;
  logic [7:0]  mem_rd_data = '0;
  logic [2:0]  result_idx;
  logic [15:0] cycle_count;
  logic [7:0]  mem [256];

  always #5 clk = ~clk;

  run_controller #(
    .DATA_W(8), .ADDR_W(8), .CNT_W(16), .START_CYCLES(S), .MAX_CYCLES(M),
    .RESULT_BASE(BASE), .RESULT_WORDS(W)
  ) dut (
    .clk(clk), .start(start), .go(go), .cpu_start(cpu_start), .cpu_halt(cpu_halt),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .result_valid(result_valid), .result_data(result_data), .result_idx(result_idx),
    .busy(busy), .done(done), .timeout(timeout), .cycle_count(cycle_count),
    .checksum(checksum)
  );

  // Synchronous-read data memory: data valid the cycle after the strobe
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

  int  cyc = 0;
  bit  run_on = 0, chk_en = 0, no_halt = 0, next_nohalt = 0;
  int  g_cyc = 0, h_run = 0, next_h = 0;
  int  words [W];
  int  total = 0, bad = 0;
  int  n_start_hi = 0, n_rden = 0, n_valid = 0, n_rise = 0;
  bit  prev_start = 0;

  // Run timeline, with rs = first RUN cycle: halting runs reach DONE at rs+h+W+2
  function automatic int endCycle();
    if (!no_halt) return g_cyc + S + h_run + W + 2;
`ifdef RUN_CTRL_CYCLE_LIMIT_EN
    return g_cyc + S + M;
`else
    return 32'h3fff_ffff;
`endif
  endfunction

  function automatic int capCount();
    if (!no_halt) return h_run;
`ifdef RUN_CTRL_CYCLE_LIMIT_EN
    return M;
`else
    return 65535;
`endif
  endfunction

  // Garbage halt during START, then halt over the last RUN cycle and into READ
  function automatic bit haltRule(int c);
    int rs;
    if (!run_on) return 1'b0;
    rs = g_cyc + S;
    if (c >= g_cyc && c < rs) return 1'b1;
    if (!no_halt && c >= rs + h_run && c <= rs + h_run + 2) return 1'b1;
    return 1'b0;
  endfunction

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic checkOutput();
    int c, rs, r0, e_cnt, n, s, cap;
    bit e_start, e_busy, e_done, e_to, e_rden, e_valid;
    c = cyc;
    if (!run_on) begin
      checkValue("cpu_start", 32'(cpu_start), 0);
      checkValue("busy", 32'(busy), 0);
      checkValue("done", 32'(done), 0);
      checkValue("timeout", 32'(timeout), 0);
      checkValue("mem_rd_en", 32'(mem_rd_en), 0);
      checkValue("mem_addr", 32'(mem_addr), 0);
      checkValue("result_valid", 32'(result_valid), 0);
      checkValue("result_data", 32'(result_data), 0);
      checkValue("result_idx", 32'(result_idx), 0);
      checkValue("cycle_count", 32'(cycle_count), 0);
      checkValue("checksum", 32'(checksum), 0);
    end else begin
      rs  = g_cyc + S;
      r0  = rs + h_run + 1;
      cap = capCount();
      e_start = (c >= g_cyc) && (c < rs);
      e_busy  = (c >= g_cyc) && (c < endCycle());
      e_done  = (c >= endCycle());
      e_to    = no_halt && e_done;
      e_rden  = !no_halt && (c >= r0) && (c < r0 + W);
      e_valid = !no_halt && (c >= r0 + 2) && (c < r0 + W + 2);
      e_cnt   = (c < rs) ? 0 : (((c - rs) < cap) ? (c - rs) : cap);
      n = no_halt ? 0 : (c - r0 - 1);
      if (n < 0) n = 0;
      if (n > W) n = W;
      s = 0;
      for (int i = 0; i < n; i++) s += words[i];
      checkValue("cpu_start", 32'(cpu_start), 32'(e_start));
      checkValue("busy", 32'(busy), 32'(e_busy));
      checkValue("done", 32'(done), 32'(e_done));
      checkValue("timeout", 32'(timeout), 32'(e_to));
      checkValue("mem_rd_en", 32'(mem_rd_en), 32'(e_rden));
      checkValue("result_valid", 32'(result_valid), 32'(e_valid));
      checkValue("cycle_count", 32'(cycle_count), e_cnt);
      checkValue("checksum", 32'(checksum), s & 255);
      if (e_rden) checkValue("mem_addr", 32'(mem_addr), (BASE + c - r0) & 255);
      if (e_valid) begin
        checkValue("result_idx", 32'(result_idx), c - r0 - 2);
        checkValue("result_data", 32'(result_data), words[c - r0 - 2]);
      end
    end
    if (cpu_start === 1'b1) n_start_hi++;
    if (cpu_start === 1'b1 && !prev_start) n_rise++;
    prev_start = (cpu_start === 1'b1);
    if (mem_rd_en === 1'b1) n_rden++;
    if (result_valid === 1'b1) n_valid++;
  endtask

  // One clock cycle: inputs set before the edge, halt driven just after it, outputs checked at negedge
  task automatic applyStimulus(input bit do_go, input bit do_rst);
    go    = do_go;
    start = do_rst;
    @(posedge clk);
    cyc++;
    if (do_rst) begin
      run_on = 0;
      chk_en = 1;
    end else if (do_go && (!run_on || (cyc - 1 >= endCycle()))) begin
      run_on  = 1;
      g_cyc   = cyc;
      h_run   = next_h;
      no_halt = next_nohalt;
      for (int i = 0; i < W; i++) words[i] = int'(mem[(BASE + i) & 255]);
    end
    #1;
    go       = 1'b0;
    start    = 1'b0;
    cpu_halt = haltRule(cyc);
    @(negedge clk);
    if (chk_en) checkOutput();
  endtask

  task automatic runToDone();
    int guard = 0;
    while (cyc < endCycle() + 2 && guard < 500) begin
      applyStimulus(0, 0);
      guard++;
    end
    if (guard >= 500) checkValue("run_bound", 32'(guard), 0);
  endtask

  initial begin
    int s_hi, s_rd, s_val, s_rise;
    start = 1'b0; go = 1'b0; cpu_halt = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    applyStimulus(0, 1);
    repeat (3) applyStimulus(0, 0);
    checkValue("reset_busy", 32'(busy), 0);
    checkValue("reset_count", 32'(cycle_count), 0);

    // Normal run
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'h04;
    next_h = 10; next_nohalt = 0;
    s_hi = n_start_hi; s_rd = n_rden; s_val = n_valid;
    applyStimulus(1, 0);
    runToDone();
    checkValue("t1_count", 32'(cycle_count), 10);
    checkValue("t1_checksum", 32'(checksum), 32'h0A);
    checkValue("t1_done", 32'(done), 1);
    checkValue("t1_timeout", 32'(timeout), 0);
    checkValue("t1_start_cycles", n_start_hi - s_hi, 2);
    checkValue("t1_rd_cycles", n_rden - s_rd, 4);
    checkValue("t1_valid_pulses", n_valid - s_val, 4);

    // Back-to-back run launched from DONE
    next_h = 3;
    applyStimulus(1, 0);
    checkValue("b2b_done_drop", 32'(done), 0);
    checkValue("b2b_count_clear", 32'(cycle_count), 0);
    runToDone();
    checkValue("b2b_count", 32'(cycle_count), 3);
    checkValue("b2b_checksum", 32'(checksum), 32'h0A);

    // Checksum wrap
    mem[0] = 8'hFF; mem[1] = 8'h02; mem[2] = 8'h00; mem[3] = 8'h00;
    next_h = 5;
    applyStimulus(1, 0);
    runToDone();
    checkValue("wrap_checksum", 32'(checksum), 32'h01);

    // go while busy is ignored
    next_h = 6;
    s_rise = n_rise;
    applyStimulus(1, 0);
    applyStimulus(1, 0);
    while (cyc < g_cyc + S + 3) applyStimulus(0, 0);
    applyStimulus(1, 0);
    runToDone();
    checkValue("busy_go_starts", n_rise - s_rise, 1);
    checkValue("busy_go_count", 32'(cycle_count), 6);
    checkValue("busy_go_done", 32'(done), 1);

    // Reset after the second read request
    next_h = 4;
    s_rd = n_rden; s_val = n_valid;
    applyStimulus(1, 0);
    while (cyc < g_cyc + S + h_run + 2) applyStimulus(0, 0);
    applyStimulus(0, 1);
    checkValue("rst_busy", 32'(busy), 0);
    checkValue("rst_rd_en", 32'(mem_rd_en), 0);
    repeat (6) applyStimulus(0, 0);
    checkValue("rst_rd_cycles", n_rden - s_rd, 2);
    checkValue("rst_valid_pulses", n_valid - s_val, 0);

`ifdef RUN_CTRL_CYCLE_LIMIT_EN
    next_nohalt = 1;
    s_rd = n_rden;
    applyStimulus(1, 0);
    runToDone();
    checkValue("to_count", 32'(cycle_count), 20);
    checkValue("to_timeout", 32'(timeout), 1);
    checkValue("to_done", 32'(done), 1);
    checkValue("to_rd_cycles", n_rden - s_rd, 0);
`else
    next_nohalt = 1;
    applyStimulus(1, 0);
    repeat (30) applyStimulus(0, 0);
    checkValue("nolimit_count", 32'(cycle_count), 28);
    checkValue("nolimit_timeout", 32'(timeout), 0);
    checkValue("nolimit_busy", 32'(busy), 1);
`endif
    applyStimulus(0, 1);
    repeat (2) applyStimulus(0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
